alu_issue_sequencer: RTL and testbench

- Multi-cycle issue/writeback stage directly upstream and downstream of the `alu`.
- Accepts one 16-bit instruction at a time and reads operands from an internal 8x16 register file.
- Drives the ALU's opcode, input1, input2 and alu_enable, then writes alu_out back to the destination register.
- Forms the execute core of the binary processor between fetch and the ALU.

---
 rtl/alu_issue_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// alu_issue_sequencer
//
// Purpose:
//   Multi-cycle issue/writeback stage wrapped around the `alu`. It accepts
//   one 16-bit instruction at a time and reads its operands from an internal
//   8x16 register file. It drives the ALU opcode, operands and enable, then
//   writes alu_result back to the destination register.
//   Instruction format: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2,
//   [4:0] imm5 (imm5 overlaps rs2).
//   FSM: IDLE -> DECODE -> EXEC (ALU_LATENCY cycles) -> WB -> IDLE.
//   An illegal opcode goes DECODE -> WB and never enables the ALU.
//
// Optional feature:
//   `define ALU_ISSUE_RETIRE_COUNT_EN adds the output retire_count[15:0].
//   This 16-bit wrapping count of retired instructions (illegal included)
//   is cleared by reset.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instr[15:0]           instruction word
//   alu_opcode/input1/2   registered ALU drive; these hold their values
//                         outside DECODE/EXEC
//   alu_enable            high for exactly ALU_LATENCY cycles per legal op
//   alu_result            ALU output, sampled during WB
//   done, illegal         one-cycle retire pulses (illegal only for
//                         unknown opcodes)
//   reg_wr_en/addr/data   register preload, honoured only in IDLE
//   dbg_addr, dbg_data    combinational register read (r0 reads as 0)
//   retire_count[15:0]    present only with ALU_ISSUE_RETIRE_COUNT_EN
// ---------------------------------------------------------------------------
module alu_issue_sequencer #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_REGS    = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [15:0]          instr,
  output logic [4:0]           alu_opcode,
  output logic [WORD_SIZE-1:0] alu_input1,
  output logic [WORD_SIZE-1:0] alu_input2,
  output logic                 alu_enable,
  input  logic [WORD_SIZE-1:0] alu_result,
  output logic                 done,
  output logic                 illegal,
  input  logic                 reg_wr_en,
  input  logic [2:0]           reg_wr_addr,
  input  logic [WORD_SIZE-1:0] reg_wr_data,
  input  logic [2:0]           dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
  ,
  output logic [15:0]          retire_count
`endif
);

  // FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  // ALU opcode map, shared with the `alu`
  localparam logic [4:0] OP_NOT  = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_XOR  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_COMP = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_ANDI = 5'd8;
  localparam logic [4:0] OP_SRI  = 5'd9;
  localparam logic [4:0] OP_SLI  = 5'd10;

  // Wide enough for the largest supported latency (count 0..3)
  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

  // State
  logic [1:0]           state_q, state_d;
  logic [15:0]          instr_q, instr_d;
  logic                 legal_q, legal_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           alu_opcode_q, alu_opcode_d;
  logic [WORD_SIZE-1:0] alu_input1_q, alu_input1_d;
  logic [WORD_SIZE-1:0] alu_input2_q, alu_input2_d;
  logic                 alu_enable_q, alu_enable_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0] regs_d [NUM_REGS];

  // Fields of the latched instruction
  logic [4:0] dec_op;
  logic [2:0] dec_rd;
  logic [2:0] dec_rs1;
  logic [2:0] dec_rs2;
  logic [4:0] dec_imm5;

  assign dec_op   = instr_q[15:11];
  assign dec_rd   = instr_q[10:8];
  assign dec_rs1  = instr_q[7:5];
  assign dec_rs2  = instr_q[4:2];
  assign dec_imm5 = instr_q[4:0];

  // Opcode classification
  logic op_legal;
  logic op_imm;
  logic op_not;

  always_comb begin
    op_legal = 1'b0;
    op_imm   = 1'b0;
    op_not   = 1'b0;
    case (dec_op)
      OP_NOT:                          begin op_legal = 1'b1; op_not = 1'b1; end
      OP_AND, OP_OR, OP_XOR,
      OP_ADD, OP_SUB, OP_COMP:         op_legal = 1'b1;
      OP_ADDI, OP_ANDI, OP_SRI, OP_SLI: begin op_legal = 1'b1; op_imm = 1'b1; end
      default:                         op_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    legal_d      = legal_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_input1_d = alu_input1_q;
    alu_input2_d = alu_input2_q;
    alu_enable_d = alu_enable_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      S_IDLE: begin
        // A preload and an accept may share this edge. The accepted
        // instruction only reads the registers in DECODE, so it sees
        // the preloaded value.
        if (reg_wr_en) begin
          regs_d[reg_wr_addr] = reg_wr_data;
        end
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op_legal) begin
          alu_opcode_d = dec_op;
          alu_input1_d = regs_q[dec_rs1];
          if (op_not) begin
            alu_input2_d = '0;
          end else if (op_imm) begin
            alu_input2_d = {{(WORD_SIZE-5){1'b0}}, dec_imm5};
          end else begin
            alu_input2_d = regs_q[dec_rs2];
          end
          alu_enable_d = 1'b1;
          cnt_d        = '0;
          legal_d      = 1'b1;
          state_d      = S_EXEC;
        end else begin
          // An unknown opcode retires at once and never enables the ALU.
          legal_d   = 1'b0;
          done_d    = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_WB;
        end
      end

      S_EXEC: begin
        // alu_enable has been high since DECODE. Drop it on the edge
        // that enters WB, once ALU_LATENCY cycles have elapsed.
        if (cnt_q == CNT_LAST) begin
          alu_enable_d = 1'b0;
          done_d       = 1'b1;
          state_d      = S_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        if (legal_q) begin
          regs_d[dec_rd] = alu_result;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // r0 is hard-wired to zero, whatever the write source.
    regs_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      legal_q      <= 1'b0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_enable_q <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      legal_q      <= legal_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_input1_q <= alu_input1_d;
      alu_input2_q <= alu_input2_d;
      alu_enable_q <= alu_enable_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef ALU_ISSUE_RETIRE_COUNT_EN
  logic [15:0] retire_count_q, retire_count_d;

  // Count while done is high, so the count covers the retiring
  // instruction from the following cycle on.
  always_comb begin
    retire_count_d = retire_count_q;
    if (done_q) begin
      retire_count_d = retire_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count_q <= '0;
    end else begin
      retire_count_q <= retire_count_d;
    end
  end

  assign retire_count = retire_count_q;
`endif

  assign instr_ready = (state_q == S_IDLE);
  assign alu_opcode  = alu_opcode_q;
  assign alu_input1  = alu_input1_q;
  assign alu_input2  = alu_input2_q;
  assign alu_enable  = alu_enable_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_data    = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for alu_issue_sequencer. An ALU stand-in registers its result while
// alu_enable is high. A reference register-file model holds the expected
// architectural state, and each instruction's expected timing is derived
// from the FSM description: done arrives 2+LAT cycles after accept, or 2
// cycles after accept for an illegal opcode.
// ---------------------------------------------------------------------------
module tb_alu_issue_sequencer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_input1;
  logic [15:0] alu_input2;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic        done;
  logic        illegal;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int tb_retired = 0;
  logic [15:0] mregs [8];

  typedef struct {
    int          done_cyc;
    int          en_cnt;
    logic        ill;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [4:0]  op;
    logic        ready_before;
    logic        done_after;
    logic        ready_after;
  } obs_t;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.WORD_SIZE(16), .NUM_REGS(8), .ALU_LATENCY(LAT)) dut (
    .clock(clk), .reset(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_enable(alu_enable), .alu_result(alu_result),
    .done(done), .illegal(illegal),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  // Behaviour of the real ALU for each opcode
  function automatic logic [15:0] alu_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      5'd0:  return ~a;
      5'd1:  return a & b;
      5'd2:  return a | b;
      5'd3:  return a ^ b;
      5'd4:  return a + b;
      5'd5:  return a - b;
      5'd6:  return (a < b) ? 16'd1 : 16'd0;
      5'd7:  return a + b;
      5'd8:  return a & b;
      5'd9:  return a >> b;
      5'd10: return a << b;
      default: return 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) alu_result <= 16'h0000;
    else if (alu_enable) alu_result <= alu_ref(alu_opcode, alu_input1, alu_input2);
  end

  function automatic bit is_legal(input logic [15:0] ins);
    return ins[15:11] <= 5'd10;
  endfunction

  // Expected second operand: 0 for NOT, zero-extended imm5 for the
  // immediate forms, R[rs2] otherwise.
  function automatic logic [15:0] exp_op2(input logic [15:0] ins);
    if (ins[15:11] == 5'd0) return 16'h0000;
    if (ins[15:11] >= 5'd7) return {11'b0, ins[4:0]};
    return mregs[ins[4:2]];
  endfunction

  function automatic logic [15:0] mk_rr(input int op, input int rd, input int rs1, input int rs2);
    return {5'(op), 3'(rd), 3'(rs1), 3'(rs2), 2'b00};
  endfunction

  function automatic logic [15:0] mk_ri(input int op, input int rd, input int rs1, input int imm);
    return {5'(op), 3'(rd), 3'(rs1), 5'(imm)};
  endfunction

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
    if (a != 3'd0) mregs[a] = d;
  endtask

  // Drive one instruction through the DUT and record what it did.
  task automatic run_instr(input logic [15:0] ins, input bit pre_same, input bit pre_busy,
                           input logic [2:0] pa, input logic [15:0] pd, output obs_t o);
    int cyc;
    o.en_cnt = 0; o.in1 = 16'h0; o.in2 = 16'h0; o.op = 5'h0;
    @(negedge clk);
    o.ready_before = instr_ready;
    instr = ins; instr_valid = 1'b1;
    if (pre_same) begin reg_wr_en = 1'b1; reg_wr_addr = pa; reg_wr_data = pd; end
    @(negedge clk);
    instr_valid = 1'b0; reg_wr_en = 1'b0; instr = 16'($urandom);
    if (pre_busy) begin reg_wr_en = 1'b1; reg_wr_addr = pa; reg_wr_data = pd; end
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      if (alu_enable === 1'b1) begin
        o.en_cnt++; o.in1 = alu_input1; o.in2 = alu_input2; o.op = alu_opcode;
      end
      @(negedge clk);
      reg_wr_en = 1'b0;
      cyc++;
    end
    if (alu_enable === 1'b1) o.en_cnt++;
    o.done_cyc = cyc;
    o.ill = illegal;
    if (done === 1'b1) tb_retired++;
    @(negedge clk);
    o.done_after = done;
    o.ready_after = instr_ready;
    $display("instr %h: done_cyc=%0d en_cycles=%0d illegal=%0b in1=%h in2=%h",
             ins, o.done_cyc, o.en_cnt, o.ill, o.in1, o.in2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    tb_retired = 0;
    n_cmp++;
    if ({instr_ready, alu_enable, done, illegal} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_ctrl: got rdy/en/done/ill=%b need 1000", {instr_ready, alu_enable, done, illegal});
    end
    n_cmp++;
    if ({alu_opcode, alu_input1, alu_input2} !== 37'h0) begin
      n_bad++; $display("FAIL reset_drive: got op=%h in1=%h in2=%h need zeros", alu_opcode, alu_input1, alu_input2);
    end
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r); #1;
      n_cmp++;
      if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL reset_reg%0d: got %h need 0000", r, dbg_data); end
    end
  endtask

  task automatic test_add();
    obs_t o;
    preload(3'd1, 16'h1234);
    preload(3'd2, 16'h5678);
    run_instr(mk_rr(4, 3, 1, 2), 1'b0, 1'b0, 3'd0, 16'h0, o);
    n_cmp++;
    if (o.ready_before !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b need 1", o.ready_before); end
    n_cmp++;
    if (o.en_cnt != LAT) begin n_bad++; $display("FAIL add_en_cycles: got %0d need %0d", o.en_cnt, LAT); end
    n_cmp++;
    if (o.done_cyc != 2 + LAT) begin n_bad++; $display("FAIL add_done_cyc: got %0d need %0d", o.done_cyc, 2 + LAT); end
    n_cmp++;
    if ({o.op, o.in1, o.in2, o.ill} !== {5'd4, 16'h1234, 16'h5678, 1'b0}) begin
      n_bad++; $display("FAIL add_drive: got op=%h in1=%h in2=%h ill=%b need 04/1234/5678/0", o.op, o.in1, o.in2, o.ill);
    end
    n_cmp++;
    if (o.done_after !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse: done still %b", o.done_after); end
    dbg_addr = 3'd3; #1;
    n_cmp++;
    if (dbg_data !== 16'h68AC) begin n_bad++; $display("FAIL add_r3: got %h need 68AC", dbg_data); end
    mregs[3] = 16'h68AC;
  endtask

  task automatic test_imm_raw();
    obs_t o;
    preload(3'd1, 16'h00FF);
    run_instr(mk_ri(10, 4, 1, 8), 1'b0, 1'b0, 3'd0, 16'h0, o);
    n_cmp++;
    if (o.in2 !== 16'h0008) begin n_bad++; $display("FAIL sli_in2: got %h need 0008", o.in2); end
    dbg_addr = 3'd4; #1;
    n_cmp++;
    if (dbg_data !== 16'hFF00) begin n_bad++; $display("FAIL sli_r4: got %h need FF00", dbg_data); end
    mregs[4] = 16'hFF00;
    run_instr(mk_ri(9, 5, 4, 4), 1'b0, 1'b0, 3'd0, 16'h0, o);
    n_cmp++;
    if (o.in1 !== 16'hFF00) begin n_bad++; $display("FAIL sri_raw_in1: got %h need FF00", o.in1); end
    dbg_addr = 3'd5; #1;
    n_cmp++;
    if (dbg_data !== 16'h0FF0) begin n_bad++; $display("FAIL sri_r5: got %h need 0FF0", dbg_data); end
    mregs[5] = 16'h0FF0;
  endtask

  task automatic test_illegal();
    obs_t o;
    run_instr(mk_rr(23, 1, 2, 3), 1'b0, 1'b0, 3'd0, 16'h0, o);
    n_cmp++;
    if ({o.ill, o.done_cyc[7:0], o.en_cnt[7:0]} !== {1'b1, 8'd2, 8'd0}) begin
      n_bad++; $display("FAIL illegal_flow: got ill=%b done_cyc=%0d en=%0d need 1/2/0", o.ill, o.done_cyc, o.en_cnt);
    end
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r); #1;
      n_cmp++;
      if (dbg_data !== mregs[r]) begin n_bad++; $display("FAIL illegal_r%0d: got %h need %h", r, dbg_data, mregs[r]); end
    end
  endtask

  task automatic test_r0();
    obs_t o;
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    run_instr(mk_rr(4, 0, 1, 2), 1'b0, 1'b0, 3'd0, 16'h0, o);
    n_cmp++;
    if (o.done_cyc != 2 + LAT) begin n_bad++; $display("FAIL r0_done_cyc: got %0d need %0d", o.done_cyc, 2 + LAT); end
    dbg_addr = 3'd0; #1;
    n_cmp++;
    if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL r0_wb: got %h need 0000", dbg_data); end
    preload(3'd0, 16'hBEEF);
    dbg_addr = 3'd0; #1;
    n_cmp++;
    if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL r0_preload: got %h need 0000", dbg_data); end
  endtask

  task automatic test_preload_rules();
    obs_t o;
    logic [15:0] exp;
    // Preload on the accept edge is visible to the accepted instruction.
    mregs[1] = 16'h1111;
    exp = mregs[1] + mregs[2];
    run_instr(mk_rr(4, 7, 1, 2), 1'b1, 1'b0, 3'd1, 16'h1111, o);
    n_cmp++;
    if (o.in1 !== 16'h1111) begin n_bad++; $display("FAIL same_edge_in1: got %h need 1111", o.in1); end
    dbg_addr = 3'd7; #1;
    n_cmp++;
    if (dbg_data !== exp) begin n_bad++; $display("FAIL same_edge_r7: got %h need %h", dbg_data, exp); end
    mregs[7] = exp;
    // Preload while busy must be dropped.
    exp = mregs[2] + mregs[2];
    run_instr(mk_rr(4, 3, 2, 2), 1'b0, 1'b1, 3'd6, 16'hABCD, o);
    mregs[3] = exp;
    dbg_addr = 3'd6; #1;
    n_cmp++;
    if (dbg_data !== mregs[6]) begin n_bad++; $display("FAIL busy_preload_r6: got %h need %h", dbg_data, mregs[6]); end
  endtask

  task automatic test_reset_exec();
    int seen_done = 0;
    @(negedge clk);
    instr = mk_rr(3, 6, 1, 2); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (alu_enable !== 1'b1) begin n_bad++; $display("FAIL rst_exec_en: got %b need 1", alu_enable); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({instr_ready, alu_enable, done} !== 3'b100) begin
      n_bad++; $display("FAIL rst_exec_state: got rdy/en/done=%b need 100", {instr_ready, alu_enable, done});
    end
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    tb_retired = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin n_bad++; $display("FAIL rst_exec_nodone: got %0d pulses need 0", seen_done); end
    dbg_addr = 3'd6; #1;
    n_cmp++;
    if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL rst_exec_r6: got %h need 0000", dbg_data); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] ins, e1, e2, er;
    bit lg;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 4) == 0) ins = {5'($urandom_range(11, 31)), 11'($urandom)};
      else ins = {5'($urandom_range(0, 10)), 11'($urandom)};
      lg = is_legal(ins);
      e1 = mregs[ins[7:5]];
      e2 = exp_op2(ins);
      er = alu_ref(ins[15:11], e1, e2);
      run_instr(ins, 1'b0, 1'b0, 3'd0, 16'h0, o);
      n_cmp++;
      if (o.done_cyc != (lg ? 2 + LAT : 2) || o.en_cnt != (lg ? LAT : 0) || o.ill !== !lg) begin
        n_bad++; $display("FAIL rand%0d_flow: got done_cyc=%0d en=%0d ill=%b legal=%b", t, o.done_cyc, o.en_cnt, o.ill, lg);
      end
      n_cmp++;
      if (o.done_after !== 1'b0 || o.ready_after !== 1'b1) begin
        n_bad++; $display("FAIL rand%0d_after: got done=%b ready=%b need 0/1", t, o.done_after, o.ready_after);
      end
      if (lg) begin
        n_cmp++;
        if ({o.op, o.in1, o.in2} !== {ins[15:11], e1, e2}) begin
          n_bad++; $display("FAIL rand%0d_drive: got %h/%h/%h need %h/%h/%h", t, o.op, o.in1, o.in2, ins[15:11], e1, e2);
        end
        if (ins[10:8] != 3'd0) mregs[ins[10:8]] = er;
      end
      for (int r = 0; r < 8; r++) begin
        dbg_addr = 3'(r); #1;
        n_cmp++;
        if (dbg_data !== mregs[r]) begin n_bad++; $display("FAIL rand%0d_r%0d: got %h need %h", t, r, dbg_data, mregs[r]); end
      end
    end
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
    n_cmp++;
    if (retire_count !== 16'(tb_retired)) begin
      n_bad++; $display("FAIL retire_count: got %h need %h", retire_count, 16'(tb_retired));
    end
`endif
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;
    reg_wr_en = 1'b0; reg_wr_addr = 3'd0; reg_wr_data = 16'h0; dbg_addr = 3'd0;
    test_reset();
    test_add();
    test_imm_raw();
    test_illegal();
    test_r0();
    test_preload_rules();
    test_random();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
